// File: rtl/tinker_hazard_unit.sv
// Hazard and forwarding controller for the pipelined Tinker core.
// Tracks in-flight register writes in a DEPTH-entry shifting scoreboard
// (entry 0 = EX, entry DEPTH-1 = last stage before register-file commit)
// and produces issue/stall/flush decisions plus forwarding selects for ID.
module tinker_hazard_unit #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1),
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_uses_rd,
  input  logic              id_writes_rd,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  input  logic              ext_stall,
  output logic              issue,
  output logic              stall_front,
  output logic              flush_front,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic [SEL_W-1:0]  fwd_rd_sel,
  output logic [SEL_W-1:0]  inflight,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Scoreboard: one {v, rd, ld} record per pipeline stage
  logic [DEPTH-1:0]             v_q, v_d;
  logic [DEPTH-1:0]             ld_q, ld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  // Per-entry operand match and "load data not ready yet" flags
  logic [DEPTH-1:0] rs_hit, rt_hit, rd_hit, early_ld;

  logic             issue_c, stall_c, flush_c, hazard_c;
  logic             rs_haz, rt_haz, rd_haz;
  logic [SEL_W-1:0] rs_sel, rt_sel, rd_sel, inflight_c;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign rs_hit[gi]   = id_uses_rs & v_q[gi] & (rd_q[gi] == id_rs);
      assign rt_hit[gi]   = id_uses_rt & v_q[gi] & (rd_q[gi] == id_rt);
      assign rd_hit[gi]   = id_uses_rd & v_q[gi] & (rd_q[gi] == id_rd);
      assign early_ld[gi] = ld_q[gi] & (gi < LOAD_READY);

      // Entry 0 takes the issuing instruction (or a bubble); the rest shift
      if (gi == 0) begin : g_head
        assign v_d[gi]  = issue_c & id_writes_rd;
        assign ld_d[gi] = issue_c & id_is_load;
        assign rd_d[gi] = issue_c ? id_rd : '0;
      end else begin : g_tail
        assign v_d[gi]  = v_q[gi-1];
        assign ld_d[gi] = ld_q[gi-1];
        assign rd_d[gi] = rd_q[gi-1];
      end
    end
  endgenerate

  // Youngest producer wins: scan oldest-to-youngest so lower indices override
  always_comb begin
    rs_sel = '0;
    rt_sel = '0;
    rd_sel = '0;
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    rd_haz = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rs_hit[i]) begin
        rs_sel = SEL_W'(i + 1);
        rs_haz = early_ld[i];
      end
      if (rt_hit[i]) begin
        rt_sel = SEL_W'(i + 1);
        rt_haz = early_ld[i];
      end
      if (rd_hit[i]) begin
        rd_sel = SEL_W'(i + 1);
        rd_haz = early_ld[i];
      end
    end
  end

  // Issue decision: memory freeze > redirect flush > load-use stall > issue
  always_comb begin
    hazard_c = id_valid & (rs_haz | rt_haz | rd_haz);
    issue_c  = 1'b0;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    if (ext_stall) begin
      stall_c = 1'b1;
    end else if (ex_redirect) begin
      flush_c = 1'b1;
    end else if (hazard_c) begin
      stall_c = 1'b1;
    end else begin
      issue_c = id_valid;
    end
  end

  // Count valid scoreboard entries
  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      inflight_c = inflight_c + SEL_W'(v_q[i]);
    end
  end

  // Saturating front-end stall counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && !flush_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Scoreboard advances unless memory freezes the whole pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q  <= '0;
      ld_q <= '0;
      rd_q <= '0;
    end else if (!ext_stall) begin
      v_q  <= v_d;
      ld_q <= ld_d;
      rd_q <= rd_d;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Combinational outputs are held at zero while reset is asserted
  assign issue        = ~reset & issue_c;
  assign stall_front  = ~reset & stall_c;
  assign flush_front  = ~reset & flush_c;
  assign fwd_rs_sel   = reset ? '0 : rs_sel;
  assign fwd_rt_sel   = reset ? '0 : rt_sel;
  assign fwd_rd_sel   = reset ? '0 : rd_sel;
  assign inflight     = reset ? '0 : inflight_c;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_tinker_hazard_unit.sv
// Self-checking bench for tinker_hazard_unit (default parameters).
module tb_tinker_hazard_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_uses_rd = 1'b0;
  logic        id_writes_rd = 1'b0, id_is_load = 1'b0;
  logic        ex_redirect = 1'b0, ext_stall = 1'b0;
  logic        issue, stall_front, flush_front;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel, fwd_rd_sel, inflight;
  logic [31:0] stall_cycles;

  typedef struct packed {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       urs, urt, urd, wr, ld, redir, xs;
  } stim_t;

  typedef struct packed {
    logic        issue, stall, flush;
    logic [1:0]  rs_sel, rt_sel, rd_sel, infl;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   model_cnt = 0;

  tinker_hazard_unit dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_uses_rd   (id_uses_rd),
    .id_writes_rd (id_writes_rd),
    .id_is_load   (id_is_load),
    .ex_redirect  (ex_redirect),
    .ext_stall    (ext_stall),
    .issue        (issue),
    .stall_front  (stall_front),
    .flush_front  (flush_front),
    .fwd_rs_sel   (fwd_rs_sel),
    .fwd_rt_sel   (fwd_rt_sel),
    .fwd_rd_sel   (fwd_rd_sel),
    .inflight     (inflight),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk_s(input int v, rs, rt, rd, urs, urt, urd, wr, ld, redir, xs);
    stim_t s;
    s.v = 1'(v); s.rs = 5'(rs); s.rt = 5'(rt); s.rd = 5'(rd);
    s.urs = 1'(urs); s.urt = 1'(urt); s.urd = 1'(urd);
    s.wr = 1'(wr); s.ld = 1'(ld); s.redir = 1'(redir); s.xs = 1'(xs);
    return s;
  endfunction

  function automatic exp_t mk_e(input int iss, stl, fls, rs, rt, rd, infl);
    exp_t e;
    e.issue = 1'(iss); e.stall = 1'(stl); e.flush = 1'(fls);
    e.rs_sel = 2'(rs); e.rt_sel = 2'(rt); e.rd_sel = 2'(rd);
    e.infl = 2'(infl); e.cnt = '0;
    return e;
  endfunction

  function automatic exp_t observe();
    return {issue, stall_front, flush_front, fwd_rs_sel, fwd_rt_sel,
            fwd_rd_sel, inflight, stall_cycles};
  endfunction

  task automatic apply(input stim_t s);
    id_valid = s.v; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
    id_uses_rs = s.urs; id_uses_rt = s.urt; id_uses_rd = s.urd;
    id_writes_rd = s.wr; id_is_load = s.ld;
    ex_redirect = s.redir; ext_stall = s.xs;
  endtask

  task automatic test_reset();
    exp_t got, want;
    apply(mk_s(1, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0));
    want = mk_e(0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(want);
    #2;
    got = observe(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("FAIL reset_hold got=%h want=%h", got, want);
    else begin passes++; $display("reset_hold ok %h", got); end
    @(posedge clk); #1;
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
  endtask

  task automatic test_forward();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(mk_s(1, 1, 2, 3, 1, 1, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_s(1, 3, 3, 4, 1, 1, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 1, 1, 0, 1));
    s.push_back(mk_s(1, 3, 4, 5, 1, 1, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 2, 1, 0, 2));
    s.push_back(mk_s(1, 5, 4, 3, 1, 0, 1, 0, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 1, 0, 3, 3));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 2));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 1));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      want = e[i]; want.cnt = 32'(model_cnt); exp_q.push_back(want);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL forward_row%0d got=%h want=%h", i, got, want);
      else begin passes++; $display("forward row%0d ok %h", i, got); end
      if (want.stall && !want.flush) model_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(mk_s(1, 0, 0, 5, 0, 0, 0, 1, 1, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_s(1, 5, 1, 6, 1, 1, 0, 1, 0, 0, 0)); e.push_back(mk_e(0, 1, 0, 1, 0, 0, 1));
    s.push_back(mk_s(1, 5, 1, 6, 1, 1, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 2, 0, 0, 1));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 2));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 1));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 1));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      want = e[i]; want.cnt = 32'(model_cnt); exp_q.push_back(want);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL load_use_row%0d got=%h want=%h", i, got, want);
      else begin passes++; $display("load_use row%0d ok %h", i, got); end
      if (want.stall && !want.flush) model_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(mk_s(1, 0, 0, 7, 0, 0, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 0, 1));
    s.push_back(mk_s(1, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 1, 0, 0, 2));
    s.push_back(mk_s(1, 0, 0, 7, 1, 0, 1, 0, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 2, 0, 1, 3));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 2));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 1));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      want = e[i]; want.cnt = 32'(model_cnt); exp_q.push_back(want);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL youngest_row%0d got=%h want=%h", i, got, want);
      else begin passes++; $display("youngest row%0d ok %h", i, got); end
      if (want.stall && !want.flush) model_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(mk_s(1, 0, 0, 5, 0, 0, 0, 1, 1, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_s(1, 5, 0, 6, 1, 0, 0, 1, 0, 1, 0)); e.push_back(mk_e(0, 0, 1, 1, 0, 0, 1));
    s.push_back(mk_s(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 2, 0, 0, 1));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 1));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      want = e[i]; want.cnt = 32'(model_cnt); exp_q.push_back(want);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL redirect_row%0d got=%h want=%h", i, got, want);
      else begin passes++; $display("redirect row%0d ok %h", i, got); end
      if (want.stall && !want.flush) model_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ext_stall();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(mk_s(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_s(1, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) begin
      s.push_back(mk_s(1, 2, 1, 3, 1, 1, 0, 1, 0, 1, 1)); e.push_back(mk_e(0, 1, 0, 1, 2, 0, 2));
    end
    s.push_back(mk_s(1, 2, 1, 3, 1, 1, 0, 1, 0, 1, 0)); e.push_back(mk_e(0, 0, 1, 1, 2, 0, 2));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 2));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 1));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      want = e[i]; want.cnt = 32'(model_cnt); exp_q.push_back(want);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL ext_stall_row%0d got=%h want=%h", i, got, want);
      else begin passes++; $display("ext_stall row%0d ok %h", i, got); end
      if (want.stall && !want.flush) model_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_rd();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(mk_s(1, 0, 0, 9, 0, 0, 0, 1, 1, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_s(1, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0)); e.push_back(mk_e(0, 1, 0, 0, 0, 1, 1));
    s.push_back(mk_s(1, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 2, 1));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 1));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_e(0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      want = e[i]; want.cnt = 32'(model_cnt); exp_q.push_back(want);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL load_rd_row%0d got=%h want=%h", i, got, want);
      else begin passes++; $display("load_rd row%0d ok %h", i, got); end
      if (want.stall && !want.flush) model_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(mk_s(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_s(1, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 0, 1));
    s.push_back(mk_s(1, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0)); e.push_back(mk_e(1, 0, 0, 0, 0, 0, 2));
    for (int k = 0; k < 4; k++) begin
      s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); e.push_back(mk_e(0, 1, 0, 0, 0, 0, 3));
    end
    foreach (s[i]) begin
      apply(s[i]);
      want = e[i]; want.cnt = 32'(model_cnt); exp_q.push_back(want);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("FAIL async_prep_row%0d got=%h want=%h", i, got, want);
      else begin passes++; $display("async_prep row%0d ok %h", i, got); end
      if (want.stall && !want.flush) model_cnt++;
      @(posedge clk); #1;
    end
    // Full scoreboard (r3,r2,r1) and nine stall cycles just before reset
    apply(mk_s(1, 1, 2, 4, 1, 1, 0, 1, 0, 0, 0));
    want = mk_e(1, 0, 0, 3, 2, 0, 3); want.cnt = 32'(model_cnt); exp_q.push_back(want);
    #1;
    got = observe(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("FAIL pre_reset got=%h want=%h", got, want);
    else begin passes++; $display("pre_reset ok %h cnt=%0d", got, got.cnt); end
    // Mid-cycle reset must clear everything without a clock edge
    reset = 1'b1;
    want = mk_e(0, 0, 0, 0, 0, 0, 0); exp_q.push_back(want);
    #1;
    got = observe(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("FAIL async_reset got=%h want=%h", got, want);
    else begin passes++; $display("async_reset ok %h", got); end
    model_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    want = mk_e(1, 0, 0, 0, 0, 0, 0); want.cnt = 32'(model_cnt); exp_q.push_back(want);
    @(negedge clk);
    got = observe(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("FAIL post_reset_issue got=%h want=%h", got, want);
    else begin passes++; $display("post_reset_issue ok %h", got); end
    @(posedge clk); #1;
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_youngest();
    test_redirect();
    test_ext_stall();
    test_load_rd();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout passed=%0d checks=%0d", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
